fetch_prefetch_unit: RTL
========================

Name: fetch_prefetch_unit

Overview:
- Instruction-fetch consumer of the program counter. Holds the sequential fetch PC and issues word reads to the instruction ROM over a req/ack handshake.
- Buffers returned instructions, each paired with its PC, in a small FIFO and hands them to the IF/ID pipeline register with valid/ready.
- Handles branch/jump redirects by flushing the buffer and dropping in-flight data.

Parameters:
N, 32, address/data width
RESET_PC, 32'h0040_0000, first fetch address after reset (ROM base)
DEPTH, 4, FIFO entries (power of 2, >=2)
AW, 2, log2(DEPTH)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
redirect  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  N  new fetch address; bits [1:0] forced to 0
mem_req  out  1  read request to instruction ROM
mem_addr  out  N  word-aligned read address
mem_ack  in  1  ROM accepted request; mem_rdata valid this cycle
mem_rdata  in  N  instruction word
inst_valid  out  1  FIFO head holds a valid instruction
inst_ready  in  1  decode stage accepts head
inst_data  out  N  head instruction
inst_pc  out  N  PC of head instruction

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-high, port named reset.
- Reset values: fetch_pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, FIFO count=0, inst_valid=0, inst_data=0, inst_pc=0, state=IDLE.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; mem_req=1 and mem_addr held stable until mem_ack.
  - DROP: request outstanding whose data must be discarded.
- Space rule: a request is issued only if count + outstanding < DEPTH. At most one outstanding request.
- IDLE -> WAIT: next cycle after space exists.
  - mem_req and mem_addr are registered outputs: mem_addr<=fetch_pc, mem_req<=1.
  - First request appears the first clk edge after reset release.
- WAIT with mem_ack:
  - Push {fetch_pc, mem_rdata} into FIFO; fetch_pc<=fetch_pc+4.
  - If space remains after the push (count_next < DEPTH), stay in WAIT with mem_addr<=fetch_pc+4 and mem_req=1 (back-to-back, one fetch per cycle max). Otherwise -> IDLE, mem_req<=0.
- PC arithmetic is modulo 2^N; 32'hFFFF_FFFC+4 wraps to 0.
- Pop: when inst_valid & inst_ready, head advances. inst_data and inst_pc are combinational from the head entry. Push and pop in the same cycle keep count unchanged.
- Redirect (priority over everything):
  - FIFO cleared (count=0, inst_valid=0 next cycle), fetch_pc<=redirect_pc&~3.
  - Pop in the same cycle is ignored.
  - Mem_ack in the same cycle: data discarded; next state WAIT with mem_addr=redirect_pc, mem_req=1.
  - Request outstanding and no mem_ack: -> DROP. mem_req stays 1 with the old mem_addr (handshake never retracted). On mem_ack, data is discarded and the next cycle issues the request at the new fetch_pc.
  - In IDLE: next cycle WAIT at redirect_pc.
  - Redirect while in DROP: only fetch_pc updates; DROP continues.
- Reset mid-transaction: everything returns to reset values immediately. A late mem_ack is ignored (state IDLE).
- No ordering violations: FIFO output order equals fetch order; inst_pc is strictly +4 between entries unless a redirect intervenes.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds outputs perf_stall_cnt[31:0] (cycles with mem_req & !mem_ack) and perf_drop_cnt[31:0] (acked fetches discarded by redirect or DROP).
  - Both are saturating at 32'hFFFF_FFFF and reset to 0.
- Undefined: counters and ports absent; functional behaviour identical.

Test Plan:
- Reset release, ROM acks every cycle, inst_ready=1 -> mem_addr sequence 0x400000, 0x400004, 0x400008…; inst_pc matches with data in order, one per cycle.
- inst_ready=0, ROM always acks -> exactly 4 pushes; mem_req drops after the 4th ack; inst_valid=1, inst_pc=0x400000 held. Raise inst_ready -> fetch resumes at 0x400010.
- Redirect to 0x00400103 while 3 entries are buffered and no request is outstanding -> inst_valid=0 next cycle; next mem_addr=0x00400100.
- Request at 0x40000C outstanding; ROM delays ack 3 cycles; redirect to 0x400200 in the first stalled cycle -> mem_addr stays 0x40000C until ack, that data is not pushed, next request is 0x400200, and the first inst_pc out is 0x400200.
- Redirect coincident with mem_ack and pop -> FIFO empty, acked word dropped, next request at redirect_pc.
- Reset asserted mid-WAIT -> mem_req=0, inst_valid=0 immediately; after release, first mem_addr=0x400000.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetch unit: sequential PC fetch over a req/ack ROM port, small PC/instruction FIFO, redirect flush.
// Optional build macro FETCH_PERF_EN adds saturating stall/drop performance counters.
module fetch_prefetch_unit #(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = N'(32'h0040_0000),
  parameter int           DEPTH    = 4,
  parameter int           AW       = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic         mem_req,
  output logic [N-1:0] mem_addr,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata,
  output logic         inst_valid,
  input  logic         inst_ready,
  output logic [N-1:0] inst_data,
  output logic [N-1:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_stall_cnt,
  output logic [31:0]  perf_drop_cnt
`endif
);

  localparam logic [1:0]   IDLE = 2'd0;
  localparam logic [1:0]   WAIT = 2'd1;
  localparam logic [1:0]   DROP = 2'd2;
  localparam logic [AW:0]  FULL = (AW+1)'(DEPTH);
  localparam logic [N-1:0] STEP = N'(4);

  logic [1:0]    state, state_nx;
  logic [N-1:0]  fetch_pc, fetch_pc_nx, addr_nx, redir_pc, pc_inc;
  logic          req_nx;
  logic [AW:0]   count, count_nx;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [N-1:0]  fifo_pc   [DEPTH];
  logic [N-1:0]  fifo_data [DEPTH];
  logic          push, pop;

  assign redir_pc   = {redirect_pc[N-1:2], 2'b00};
  assign pc_inc     = fetch_pc + STEP;
  assign inst_valid = (count != '0);
  assign push       = (state == WAIT) && mem_ack && !redirect;
  assign pop        = inst_valid && inst_ready && !redirect;
  assign inst_data  = inst_valid ? fifo_data[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : '0;

  always_comb begin
    count_nx = count;
    if (redirect)
      count_nx = '0;
    else if (push && !pop)
      count_nx = count + (AW+1)'(1);
    else if (!push && pop)
      count_nx = count - (AW+1)'(1);
  end

  // The request handshake is never retracted: a redirect during an unacked
  // request parks in DROP with the old address until the ROM answers.
  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    req_nx      = mem_req;
    addr_nx     = mem_addr;
    case (state)
      IDLE: begin
        if (redirect) begin
          state_nx    = WAIT;
          fetch_pc_nx = redir_pc;
          req_nx      = 1'b1;
          addr_nx     = redir_pc;
        end else if (count < FULL) begin
          state_nx = WAIT;
          req_nx   = 1'b1;
          addr_nx  = fetch_pc;
        end
      end
      WAIT: begin
        if (redirect) begin
          fetch_pc_nx = redir_pc;
          if (mem_ack)
            addr_nx = redir_pc;
          else
            state_nx = DROP;
        end else if (mem_ack) begin
          fetch_pc_nx = pc_inc;
          if (count_nx < FULL) begin
            addr_nx = pc_inc;
          end else begin
            state_nx = IDLE;
            req_nx   = 1'b0;
          end
        end
      end
      DROP: begin
        if (redirect)
          fetch_pc_nx = redir_pc;
        if (mem_ack) begin
          state_nx = WAIT;
          addr_nx  = fetch_pc_nx;
        end
      end
      default: begin
        state_nx = IDLE;
        req_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      mem_req  <= req_nx;
      mem_addr <= addr_nx;
      count    <= count_nx;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= fetch_pc;
      fifo_data[wr_ptr] <= mem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  logic drop_ev;
  assign drop_ev = mem_ack && (((state == WAIT) && redirect) || (state == DROP));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (mem_req && !mem_ack && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (drop_ev && (perf_drop_cnt != '1))
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
    end
  end
`endif

endmodule
